me_serpentine_scan_ctrl: RTL and testbench
==========================================

// Module: me_serpentine_scan_ctrl
// PURPOSE
//  Parametrised full-search motion-estimation sequencer. Loads the current macroblock (CPR)
//  and the first search column (SPR) from RAM, then walks candidates (x,y) in serpentine order.
//  Per candidate it drives comp_en, the position (mv_x,mv_y) and the shift command for the
//  SAD/compare datapath. A runtime search range replaces the fixed SEARCH_DIM-MACRO_DIM sweep.
// PARAMETERS
//  MACRO_DIM   16                              macroblock edge (pixels)
//  SEARCH_DIM  48                              search window edge (pixels), > MACRO_DIM
//  ADDR_W      $clog2(SEARCH_DIM)              RAM row address width
//  POS_W       $clog2(SEARCH_DIM-MACRO_DIM+1)  candidate coordinate width
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       synchronous active-high reset
//  start      in   1       job request; accepted when start && readyi
//  cfg_range  in   POS_W   max candidate coordinate R, sampled on accept
//  readyi     out  1       idle, can accept start
//  en_cpr     out  1       load CPR row from RAM at addr
//  en_spr     out  1       SPR update enable (load or shift)
//  en_ram     out  1       RAM read enable
//  addr       out  ADDR_W  RAM row address
//  sel        out  2       SPR shift at end of cycle: 0 hold, 1 up (new bottom row), 2 down (new top row), 3 left
//  comp_en    out  1       candidate (mv_x,mv_y) valid for SAD compare this cycle
//  mv_x,mv_y  out  POS_W   current candidate position (0 when comp_en=0)
//  last       out  1       comp_en cycle of final candidate
//  amt        out  POS_W   columns shifted so far (= mv_x during scan)
//  valido     out  1       job done, held until readyo
//  readyo     in   1       downstream accepts result
// BEHAVIOUR
//  - All outputs are a registered-state decode; while rst=1 state<=IDLE, counters<=0. In the cycle after
//    reset, readyi=1 and every other output is 0. Reset mid-job aborts immediately, with no valido.
//  - R = min(cfg_range, SEARCH_DIM-MACRO_DIM), latched on accept. start while readyi=0 is ignored.
//  - IDLE: readyi=1. On accept -> LOAD_CPR next cycle.
//  - LOAD_CPR: MACRO_DIM cycles; en_cpr=en_ram=1, addr=0..MACRO_DIM-1. Then -> LOAD_SPR (row counter cleared, no gap cycle).
//  - LOAD_SPR: MACRO_DIM cycles; en_spr=en_ram=1, sel=1, addr=0..MACRO_DIM-1. Then -> SCAN at (0,0).
//  - SCAN: exactly one candidate per cycle; comp_en=en_spr=1; (R+1)^2 cycles total.
//    - Even column x: y goes 0->R. If y<R: sel=1, en_ram=1, addr=y+MACRO_DIM.
//    - Odd column x: y goes R->0. If y>0: sel=2, en_ram=1, addr=y-1.
//    - Column end (y=R even / y=0 odd) with x<R: sel=3, en_ram=0, addr=0. Next cycle x+1, amt+1, same y.
//    - Final candidate (x=R, y=R if R even else 0): last=1, sel=0, en_spr=0. -> DONE.
//    - R=0: single SCAN cycle at (0,0) with last=1.
//  - DONE: valido=1, all else 0. valido && readyo -> IDLE next cycle (readyi=1 then). amt holds its final value.
//  - Latency from accept to first comp_en: 1+2*MACRO_DIM cycles; to valido: 1+2*MACRO_DIM+(R+1)^2 cycles.
//  - All counters are unsigned POS_W/ADDR_W bits and never wrap within a legal job.
// CONFIGURATION
//  ME_EARLY_TERM_EN defined: adds input early_stop (1) and output early_done (1).
//    - early_stop=1 in a SCAN cycle makes that candidate final: last=1, sel=0, -> DONE.
//    - early_done=1 alongside valido. early_stop outside SCAN is ignored.
//    - early_done clears on the valido&&readyo handshake.
//  Not defined: ports absent; the scan always covers all (R+1)^2 candidates.
// TESTING
//  1. Default params, cfg_range=32 -> 16 en_cpr cycles (addr 0..15); 16 en_spr cycles (addr 0..15);
//     1089 comp_en cycles visiting (0,0)..(0,32),(1,32)..(1,0),... ending (32,32) with last=1;
//     valido at cycle 1122 after accept.
//  2. cfg_range=0 -> exactly one comp_en cycle at (0,0) with last=1 and sel=0; valido 34 cycles after accept.
//  3. cfg_range=40 -> clamped to R=32; same trace as test 1.
//  4. cfg_range=3, readyo held 0 for 5 cycles in DONE, start pulsed while busy -> valido stays 1;
//     start is not accepted; readyi returns 1 cycle after readyo=1.
//  5. rst=1 during SCAN at (2,5) -> next cycle readyi=1, comp_en=valido=0, amt=0; a new start runs a clean job.
//  6. ME_EARLY_TERM_EN, R=32, early_stop at (4,10) -> last=1 at (4,10); then valido=1 and early_done=1.

Source files
------------

// File: rtl/me_serpentine_scan_ctrl_if.sv
// Handshake and RAM/SPR command bundle for the serpentine ME scan controller.
// slave: controller side; master: job requester / datapath side.
interface me_serpentine_scan_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int POS_W  = 6
);
    logic              start;
    logic [POS_W-1:0]  cfg_range;
    logic              readyi;
    logic              en_cpr;
    logic              en_spr;
    logic              en_ram;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        sel;
    logic              comp_en;
    logic [POS_W-1:0]  mv_x;
    logic [POS_W-1:0]  mv_y;
    logic              last;
    logic [POS_W-1:0]  amt;
    logic              valido;
    logic              readyo;
`ifdef ME_EARLY_TERM_EN
    logic              early_stop;
    logic              early_done;

    modport slave (
        input  start, cfg_range, readyo, early_stop,
        output readyi, en_cpr, en_spr, en_ram, addr, sel,
        output comp_en, mv_x, mv_y, last, amt, valido, early_done
    );
    modport master (
        output start, cfg_range, readyo, early_stop,
        input  readyi, en_cpr, en_spr, en_ram, addr, sel,
        input  comp_en, mv_x, mv_y, last, amt, valido, early_done
    );
`else
    modport slave (
        input  start, cfg_range, readyo,
        output readyi, en_cpr, en_spr, en_ram, addr, sel,
        output comp_en, mv_x, mv_y, last, amt, valido
    );
    modport master (
        output start, cfg_range, readyo,
        input  readyi, en_cpr, en_spr, en_ram, addr, sel,
        input  comp_en, mv_x, mv_y, last, amt, valido
    );
`endif
endinterface

// File: rtl/me_serpentine_scan_ctrl.sv
// Full-search ME sequencer: loads CPR and first SPR column, then walks
// candidates (x,y) serpentine over a runtime range R = min(cfg_range, SD-MD).
// Ports: clk, rst (sync, active high), bus (slave modport of the _if):
//   start/cfg_range/readyi job accept, en_cpr/en_spr/en_ram/addr/sel RAM and
//   SPR commands, comp_en/mv_x/mv_y/last/amt candidate, valido/readyo result.
// Option: ME_EARLY_TERM_EN adds early_stop (in) and early_done (out).
module me_serpentine_scan_ctrl #(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48,
    parameter int ADDR_W     = $clog2(SEARCH_DIM),
    parameter int POS_W      = $clog2(SEARCH_DIM - MACRO_DIM + 1)
) (
    input  logic clk,
    input  logic rst,
    me_serpentine_scan_ctrl_if.slave bus
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOAD_CPR = 3'd1;
    localparam logic [2:0] LOAD_SPR = 3'd2;
    localparam logic [2:0] SCAN     = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    localparam logic [POS_W-1:0]  MAXR     = POS_W'(SEARCH_DIM - MACRO_DIM);
    localparam logic [POS_W-1:0]  ONE_P    = POS_W'(1);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(MACRO_DIM - 1);
    localparam logic [ADDR_W-1:0] MD_A     = ADDR_W'(MACRO_DIM);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [POS_W-1:0]  x_q, x_d;
    logic [POS_W-1:0]  y_q, y_d;
    logic [POS_W-1:0]  amt_q, amt_d;
    logic [POS_W-1:0]  r_q, r_d;
    logic              early_q, early_d;

    logic              stop_c;
    logic              col_end;
    logic              fin;

    logic              readyi_c, en_cpr_c, en_spr_c, en_ram_c;
    logic [ADDR_W-1:0] addr_c;
    logic [1:0]        sel_c;
    logic              comp_en_c, last_c, valido_c;
    logic [POS_W-1:0]  mv_x_c, mv_y_c;

`ifdef ME_EARLY_TERM_EN
    assign stop_c         = bus.early_stop;
    assign bus.early_done = (state_q == DONE) && early_q;
`else
    assign stop_c         = 1'b0;
`endif

    // Even columns run downwards (y 0->R), odd columns upwards (y R->0).
    assign col_end = x_q[0] ? (y_q == '0) : (y_q == r_q);
    assign fin     = (col_end && (x_q == r_q)) || stop_c;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        x_d       = x_q;
        y_d       = y_q;
        amt_d     = amt_q;
        r_d       = r_q;
        early_d   = early_q;
        readyi_c  = 1'b0;
        en_cpr_c  = 1'b0;
        en_spr_c  = 1'b0;
        en_ram_c  = 1'b0;
        addr_c    = '0;
        sel_c     = 2'd0;
        comp_en_c = 1'b0;
        mv_x_c    = '0;
        mv_y_c    = '0;
        last_c    = 1'b0;
        valido_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                readyi_c = 1'b1;
                if (bus.start) begin
                    state_d = LOAD_CPR;
                    row_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                    amt_d   = '0;
                    early_d = 1'b0;
                    r_d     = (bus.cfg_range > MAXR) ? MAXR : bus.cfg_range;
                end
            end
            LOAD_CPR: begin
                en_cpr_c = 1'b1;
                en_ram_c = 1'b1;
                addr_c   = row_q;
                row_d    = row_q + ONE_A;
                if (row_q == LAST_ROW) begin
                    state_d = LOAD_SPR;
                    row_d   = '0;
                end
            end
            LOAD_SPR: begin
                en_spr_c = 1'b1;
                en_ram_c = 1'b1;
                sel_c    = 2'd1;
                addr_c   = row_q;
                row_d    = row_q + ONE_A;
                if (row_q == LAST_ROW) begin
                    state_d = SCAN;
                    row_d   = '0;
                end
            end
            SCAN: begin
                comp_en_c = 1'b1;
                mv_x_c    = x_q;
                mv_y_c    = y_q;
                if (fin) begin
                    last_c  = 1'b1;
                    state_d = DONE;
                    early_d = stop_c;
                end else if (col_end) begin
                    // Shift left; y stays put for the next column.
                    en_spr_c = 1'b1;
                    sel_c    = 2'd3;
                    x_d      = x_q + ONE_P;
                    amt_d    = amt_q + ONE_P;
                end else if (!x_q[0]) begin
                    en_spr_c = 1'b1;
                    en_ram_c = 1'b1;
                    sel_c    = 2'd1;
                    addr_c   = ADDR_W'(y_q) + MD_A;
                    y_d      = y_q + ONE_P;
                end else begin
                    en_spr_c = 1'b1;
                    en_ram_c = 1'b1;
                    sel_c    = 2'd2;
                    addr_c   = ADDR_W'(y_q) - ONE_A;
                    y_d      = y_q - ONE_P;
                end
            end
            DONE: begin
                valido_c = 1'b1;
                if (bus.readyo) begin
                    state_d = IDLE;
                    early_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            amt_q   <= '0;
            r_q     <= '0;
            early_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            x_q     <= x_d;
            y_q     <= y_d;
            amt_q   <= amt_d;
            r_q     <= r_d;
            early_q <= early_d;
        end
    end

    assign bus.readyi  = readyi_c;
    assign bus.en_cpr  = en_cpr_c;
    assign bus.en_spr  = en_spr_c;
    assign bus.en_ram  = en_ram_c;
    assign bus.addr    = addr_c;
    assign bus.sel     = sel_c;
    assign bus.comp_en = comp_en_c;
    assign bus.mv_x    = mv_x_c;
    assign bus.mv_y    = mv_y_c;
    assign bus.last    = last_c;
    assign bus.amt     = amt_q;
    assign bus.valido  = valido_c;
endmodule

// File: tb/tb_me_serpentine_scan_ctrl.sv
// Self-checking bench for me_serpentine_scan_ctrl (default parameters).
// Per-cycle trace compared against a serpentine-order reference model.
module tb_me_serpentine_scan_ctrl;
    localparam int M  = 16;
    localparam int RM = 32;

    typedef struct packed {
        logic       rdy;
        logic       cpr;
        logic       spr;
        logic       ram;
        logic [5:0] addr;
        logic [1:0] sel;
        logic       ce;
        logic [5:0] mx;
        logic [5:0] my;
        logic       last;
        logic [5:0] amt;
        logic       vo;
        logic       ed;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   prev_amt = 0;

    me_serpentine_scan_ctrl_if #(.ADDR_W(6), .POS_W(6)) bus ();

    me_serpentine_scan_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t a;
        a      = '0;
        a.rdy  = bus.readyi;
        a.cpr  = bus.en_cpr;
        a.spr  = bus.en_spr;
        a.ram  = bus.en_ram;
        a.addr = bus.addr;
        a.sel  = bus.sel;
        a.ce   = bus.comp_en;
        a.mx   = bus.mv_x;
        a.my   = bus.mv_y;
        a.last = bus.last;
        a.amt  = bus.amt;
        a.vo   = bus.valido;
`ifdef ME_EARLY_TERM_EN
        a.ed   = bus.early_done;
`endif
        return a;
    endfunction

    // Serpentine position of candidate i for range r.
    function automatic int cand_x(input int i, input int r);
        return i / (r + 1);
    endfunction

    function automatic int cand_y(input int i, input int r);
        int k;
        k = i % (r + 1);
        return (cand_x(i, r) % 2 == 0) ? k : r - k;
    endfunction

    task automatic run_job(input int cfg, input int hold,
                           input int abort_i, input int stop_i);
        int   r, n, ne, base, fin_x, last_c, i, cx, cy, nx, ny;
        logic early;
        obs_t e, a;
        r      = (cfg > RM) ? RM : cfg;
        n      = (r + 1) * (r + 1);
        early  = (stop_i >= 0) && (stop_i < n);
        ne     = early ? stop_i + 1 : n;
        base   = 2 * M;
        fin_x  = cand_x(ne - 1, r);
        last_c = base + ne + hold + 2;
        for (int c = 0; c <= last_c; c++) begin
            @(negedge clk);
            i = c - base - 1;
            bus.start     = (c == 0) ? 1'b1
                          : (c < last_c) ? 1'($urandom) : 1'b0;
            bus.cfg_range = (c == 0) ? 6'(cfg) : 6'($urandom);
            bus.readyo    = (c == base + ne + 1 + hold) ? 1'b1
                          : (c <= base + ne) ? 1'($urandom) : 1'b0;
`ifdef ME_EARLY_TERM_EN
            if (c > base && c <= base + ne)
                bus.early_stop = early && (i == stop_i);
            else
                bus.early_stop = 1'($urandom);
`endif
            #1;
            e = '0;
            if (c == 0) begin
                e.rdy = 1'b1;
                e.amt = 6'(prev_amt);
            end else if (c <= M) begin
                e.cpr  = 1'b1;
                e.ram  = 1'b1;
                e.addr = 6'(c - 1);
            end else if (c <= base) begin
                e.spr  = 1'b1;
                e.ram  = 1'b1;
                e.sel  = 2'd1;
                e.addr = 6'(c - M - 1);
            end else if (c <= base + ne) begin
                cx    = cand_x(i, r);
                cy    = cand_y(i, r);
                e.ce  = 1'b1;
                e.mx  = 6'(cx);
                e.my  = 6'(cy);
                e.amt = 6'(cx);
                if (i == ne - 1) begin
                    e.last = 1'b1;
                end else begin
                    nx    = cand_x(i + 1, r);
                    ny    = cand_y(i + 1, r);
                    e.spr = 1'b1;
                    if (nx != cx) begin
                        e.sel = 2'd3;
                    end else if (ny > cy) begin
                        e.sel  = 2'd1;
                        e.ram  = 1'b1;
                        e.addr = 6'(cy + M);
                    end else begin
                        e.sel  = 2'd2;
                        e.ram  = 1'b1;
                        e.addr = 6'(cy - 1);
                    end
                end
            end else if (c <= base + ne + 1 + hold) begin
                e.vo  = 1'b1;
                e.amt = 6'(fin_x);
`ifdef ME_EARLY_TERM_EN
                e.ed  = early;
`endif
            end else begin
                e.rdy = 1'b1;
                e.amt = 6'(fin_x);
            end
            a = sample();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL trace cfg=%0d cyc=%0d got=%h exp=%h",
                         cfg, c, a, e);
            end
            if (c > base && i == abort_i) begin
                rst       = 1'b1;
                bus.start = 1'b0;
                @(negedge clk);
                #1;
                e     = '0;
                e.rdy = 1'b1;
                a     = sample();
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL abort_reset got=%h exp=%h", a, e);
                end
                rst      = 1'b0;
                prev_amt = 0;
                return;
            end
        end
        prev_amt = fin_x;
    endtask

    task automatic test_reset();
        obs_t e, a;
        rst           = 1'b1;
        bus.start     = 1'b1;
        bus.cfg_range = 6'd5;
        bus.readyo    = 1'b0;
`ifdef ME_EARLY_TERM_EN
        bus.early_stop = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        #1;
        e     = '0;
        e.rdy = 1'b1;
        a     = sample();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", a, e);
        end
        prev_amt = 0;
    endtask

    task automatic test_full_range();
        run_job(32, 0, -1, -1);
    endtask

    task automatic test_zero_range();
        run_job(0, 2, -1, -1);
    endtask

    task automatic test_clamp();
        run_job(40, 1, -1, -1);
    endtask

    task automatic test_backpressure();
        run_job(3, 5, -1, -1);
    endtask

    task automatic test_reset_mid_scan();
        run_job(32, 0, 2 * 33 + 5, -1);
        run_job(2, 0, -1, -1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++)
            run_job(int'($urandom_range(0, 40)),
                    int'($urandom_range(0, 4)), -1, -1);
    endtask

    task automatic test_back_to_back();
        run_job(1, 0, -1, -1);
        run_job(4, 0, -1, -1);
    endtask

`ifdef ME_EARLY_TERM_EN
    task automatic test_early_stop();
        run_job(32, 2, -1, 4 * 33 + 10);
        run_job(int'($urandom_range(1, 20)), 1, -1, 3);
    endtask
`endif

    initial begin
        test_reset();
        test_full_range();
        test_zero_range();
        test_clamp();
        test_backpressure();
        test_reset_mid_scan();
        test_random();
        test_back_to_back();
`ifdef ME_EARLY_TERM_EN
        test_early_stop();
`endif
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
